signal_capture: RTL and testbench
=================================

SIGNAL_CAPTURE -- requirements
Module: signal_capture

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, sample width in bits.
REQ-002 SHALL have parameter NB_ADDR, default 10, buffer address width; DEPTH = 2^NB_ADDR samples.
REQ-003 SHALL have port i_clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_signal  input  NB_DATA  unsigned sample stream.
REQ-006 SHALL have port i_valid  input  1  i_signal is a valid sample this cycle.
REQ-007 SHALL have port i_arm  input  1  single-cycle arm request.
REQ-008 SHALL have port i_abort  input  1  single-cycle abort request.
REQ-009 SHALL have port i_trig_level  input  NB_DATA  unsigned trigger threshold, sampled on arm.
REQ-010 SHALL have port i_pretrig  input  NB_ADDR  samples kept before trigger, sampled on arm.
REQ-011 SHALL have port i_read  input  1  start readout when done.
REQ-012 SHALL have port i_ready  input  1  readout consumer ready.
REQ-013 SHALL have port o_data  output  NB_DATA  readout sample.
REQ-014 SHALL have port o_valid  output  1  o_data valid.
REQ-015 SHALL have port o_last  output  1  final sample of readout.
REQ-016 SHALL have port o_busy  output  1  high in FILL, ARMED, POST.
REQ-017 SHALL have port o_done  output  1  high in DONE.

Function
REQ-018 SHALL implement states IDLE, FILL, ARMED, POST, DONE, READ.
REQ-019 IDLE + i_arm -> FILL if latched pretrig>0, else ARMED; latch i_trig_level, i_pretrig; wr_ptr and counters cleared; prev-sample flag cleared.
REQ-020 SHALL write each i_valid sample to mem[wr_ptr] and increment wr_ptr modulo DEPTH, in FILL, ARMED, POST only; cycles with i_valid=0 write nothing and advance nothing.
REQ-021 FILL -> ARMED after exactly pretrig samples written; triggers SHALL be ignored in FILL.
REQ-022 Trigger: valid sample in ARMED with prev < level and cur >= level (unsigned), prev being the preceding valid sample; none possible until one prior valid sample exists since arm.
REQ-023 Trigger sample SHALL be written, trig_addr = its address; ARMED -> POST; post count starts at 1.
REQ-024 ARMED SHALL overwrite circularly without limit until trigger or abort.
REQ-025 POST -> DONE once DEPTH - pretrig samples written (trigger sample included).
REQ-026 DONE + i_read -> READ, rd_ptr = (trig_addr - pretrig) mod DEPTH, read count 0.
REQ-027 In READ: o_valid=1, o_data = mem[rd_ptr] combinationally; on o_valid & i_ready, rd_ptr+1 mod DEPTH, count+1.
REQ-028 o_last SHALL be 1 when count = DEPTH-1; transfer with o_last -> IDLE.
REQ-029 With i_ready=0, o_data, o_last and rd_ptr SHALL hold.
REQ-030 i_abort in any state -> IDLE next cycle; i_abort wins over simultaneous i_arm or trigger.
REQ-031 i_arm outside IDLE, i_read outside DONE SHALL be ignored.
REQ-032 o_data SHALL be 0 when o_valid=0.
REQ-033 Readout SHALL return exactly DEPTH samples, oldest first: pretrig pre-trigger samples, then trigger sample, then post samples.

Reset
REQ-034 i_reset=0 at a rising edge SHALL force IDLE, wr_ptr, rd_ptr, all counters, latched level/pretrig to 0, all outputs 0; memory contents not reset.
REQ-035 Reset mid-capture or mid-readout SHALL abandon the operation; first post-reset cycle behaves as IDLE.

Verification (NB_DATA=8, NB_ADDR=4, DEPTH=16)
REQ-036 Arm level=100, pretrig=4, ramp 0,1,2.. every cycle -> DONE; read with i_ready=1 gives 96..111, o_last on 111.
REQ-037 Same with pretrig=0 -> readout 100..115; pretrig=15 -> 85..100.
REQ-038 Ramp with i_valid toggling 1,0,1,0 -> identical readout to REQ-036.
REQ-039 Constant input 200 after arm -> no trigger, o_busy stays 1; i_abort -> o_busy=0, IDLE next cycle.
REQ-040 Readout with i_ready low for 3 cycles at sample 5 -> o_data holds 101, no loss or duplication.
REQ-041 i_reset=0 during POST and during READ -> all outputs 0 next cycle; fresh arm then captures correctly.

Source files
------------

// File: rtl/signal_capture.sv
// signal_capture: pre/post-trigger sample capture buffer with streaming readout.
// A rising-edge level crossing in the armed state freezes a window of DEPTH
// samples around the trigger, which is then read out oldest-first.
module signal_capture #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_ADDR = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_signal,
    input  logic               i_valid,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic [NB_DATA-1:0] i_trig_level,
    input  logic [NB_ADDR-1:0] i_pretrig,
    input  logic               i_read,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_last,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned DEPTH  = 1 << NB_ADDR;
    localparam int unsigned NB_CNT = NB_ADDR + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;

    logic [2:0]         state;
    logic [2:0]         state_next;

    logic [NB_DATA-1:0] mem [DEPTH];

    logic [NB_ADDR-1:0] wr_ptr;
    logic [NB_ADDR-1:0] rd_ptr;
    logic [NB_ADDR-1:0] rd_cnt;
    logic [NB_ADDR-1:0] trig_addr;
    logic [NB_ADDR-1:0] pretrig;
    logic [NB_DATA-1:0] level;
    logic [NB_DATA-1:0] prev;
    logic               prev_seen;
    logic [NB_CNT-1:0]  cap_cnt;

    // Decoded strobes, produced by the next-state block
    logic               arm_go;
    logic               wr_en;
    logic               trig_hit;
    logic               fill_end;
    logic               post_end;
    logic               read_go;
    logic               xfer;
    logic               rd_last;
    logic [NB_CNT-1:0]  cap_cnt_inc;
    logic [NB_CNT-1:0]  post_target;

    // State register with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode; abort overrides every other request
    always_comb begin
        state_next  = state;
        arm_go      = 1'b0;
        wr_en       = 1'b0;
        trig_hit    = 1'b0;
        fill_end    = 1'b0;
        post_end    = 1'b0;
        read_go     = 1'b0;
        xfer        = 1'b0;
        rd_last     = (rd_cnt == NB_ADDR'(DEPTH - 1));
        cap_cnt_inc = cap_cnt + NB_CNT'(1);
        post_target = NB_CNT'(DEPTH) - {1'b0, pretrig};

        if (i_abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_arm) begin
                        arm_go     = 1'b1;
                        state_next = (i_pretrig != '0) ? S_FILL : S_ARMED;
                    end
                end
                S_FILL: begin
                    wr_en    = i_valid;
                    fill_end = i_valid && (cap_cnt_inc == {1'b0, pretrig});
                    if (fill_end) begin
                        state_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    wr_en    = i_valid;
                    trig_hit = i_valid && prev_seen && (prev < level) && (i_signal >= level);
                    if (trig_hit) begin
                        // With a single post slot the trigger sample completes the window
                        state_next = (post_target == NB_CNT'(1)) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wr_en    = i_valid;
                    post_end = i_valid && (cap_cnt_inc == post_target);
                    if (post_end) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_read) begin
                        read_go    = 1'b1;
                        state_next = S_READ;
                    end
                end
                S_READ: begin
                    xfer = i_ready;
                    if (i_ready && rd_last) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Capture/readout datapath registers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            trig_addr <= '0;
            pretrig   <= '0;
            level     <= '0;
            prev      <= '0;
            prev_seen <= 1'b0;
            cap_cnt   <= '0;
        end else begin
            if (arm_go) begin
                level     <= i_trig_level;
                pretrig   <= i_pretrig;
                wr_ptr    <= '0;
                cap_cnt   <= '0;
                rd_cnt    <= '0;
                prev_seen <= 1'b0;
            end

            if (wr_en) begin
                wr_ptr    <= wr_ptr + NB_ADDR'(1);
                prev      <= i_signal;
                prev_seen <= 1'b1;
                if (state == S_FILL) begin
                    cap_cnt <= fill_end ? '0 : cap_cnt_inc;
                end else if (trig_hit) begin
                    trig_addr <= wr_ptr;
                    cap_cnt   <= NB_CNT'(1);
                end else if (state == S_POST) begin
                    cap_cnt <= cap_cnt_inc;
                end
            end

            if (read_go) begin
                rd_ptr <= trig_addr - pretrig;
                rd_cnt <= '0;
            end

            if (xfer) begin
                rd_ptr <= rd_ptr + NB_ADDR'(1);
                rd_cnt <= rd_cnt + NB_ADDR'(1);
            end
        end
    end

    // Sample memory; contents deliberately survive reset
    always_ff @(posedge i_clock) begin
        if (i_reset && wr_en) begin
            mem[wr_ptr] <= i_signal;
        end
    end

    // Status and readout outputs decoded from the state register
    assign o_busy  = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
    assign o_done  = (state == S_DONE);
    assign o_valid = (state == S_READ);
    assign o_last  = (state == S_READ) && rd_last;
    assign o_data  = (state == S_READ) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_signal_capture.sv
// tb_signal_capture: table-driven and randomized checks of signal_capture
// (NB_DATA=8, NB_ADDR=4) against a sample-list reference model.
module tb_signal_capture;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_ADDR = 4;
    localparam int          DEPTH   = 16;

    logic               i_clock;
    logic               i_reset;
    logic [NB_DATA-1:0] i_signal;
    logic               i_valid;
    logic               i_arm;
    logic               i_abort;
    logic [NB_DATA-1:0] i_trig_level;
    logic [NB_ADDR-1:0] i_pretrig;
    logic               i_read;
    logic               i_ready;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               o_last;
    logic               o_busy;
    logic               o_done;

    int total;
    int bad;
    int stim[$];
    int exp_q[$];

    typedef struct {
        int p;
        int lvl;
        int vmode;
        int rmode;
        int first;
    } vec_t;

    vec_t vecs[6];

    signal_capture #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_signal     (i_signal),
        .i_valid      (i_valid),
        .i_arm        (i_arm),
        .i_abort      (i_abort),
        .i_trig_level (i_trig_level),
        .i_pretrig    (i_pretrig),
        .i_read       (i_read),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(o_busy),  0);
        chk({tag, "_done"},  32'(o_done),  0);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_last"},  32'(o_last),  0);
        chk({tag, "_data"},  32'(o_data),  0);
    endtask

    // Reference: the window is DEPTH consecutive valid samples starting pretrig
    // before the first qualifying crossing at or after sample index pretrig.
    // Returns the number of valid samples after which capture completes.
    function automatic int model_needed(input int p, input int lvl);
        exp_q.delete();
        for (int i = (p > 1 ? p : 1); i < stim.size(); i++) begin
            if (stim[i-1] < lvl && stim[i] >= lvl) begin
                if (i + DEPTH - p > stim.size()) return -1;
                for (int k = i - p; k < i - p + DEPTH; k++) exp_q.push_back(stim[k]);
                return i + DEPTH - p;
            end
        end
        return -1;
    endfunction

    task automatic arm(input int p, input int lvl);
        i_valid      = 1'b0;
        i_arm        = 1'b1;
        i_trig_level = NB_DATA'(lvl);
        i_pretrig    = NB_ADDR'(p);
        step();
        i_arm        = 1'b0;
        i_trig_level = NB_DATA'($urandom);
        i_pretrig    = NB_ADDR'($urandom);
    endtask

    // vmode: 0 every cycle valid, 1 alternating, 2 random with stray arm/read pulses
    task automatic capture(input int p, input int lvl, input int vmode, input int needed);
        int k;
        int cyc;
        bit vld;
        k   = 0;
        cyc = 0;
        arm(p, lvl);
        chk("busy_after_arm", 32'(o_busy), 1);
        while (k < needed && cyc < 2000) begin
            case (vmode)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2 == 0);
                default: vld = ($urandom_range(0, 3) != 0);
            endcase
            i_valid  = vld;
            i_signal = vld ? NB_DATA'(stim[k]) : NB_DATA'($urandom);
            if (vmode == 2) begin
                i_arm        = ($urandom_range(0, 7) == 0);
                i_read       = ($urandom_range(0, 7) == 0);
                i_trig_level = NB_DATA'($urandom);
                i_pretrig    = NB_ADDR'($urandom);
            end
            step();
            if (vld) k++;
            cyc++;
            chk("done_timing", 32'(o_done), 32'(k >= needed));
            chk("busy_timing", 32'(o_busy), 32'(k < needed));
        end
        i_valid = 1'b0;
        i_arm   = 1'b0;
        i_read  = 1'b0;
        if (k < needed) chk("capture_timeout", 32'(k), 32'(needed));
    endtask

    // rmode: 0 always ready, 1 random ready, 2 three-cycle stall at sample 5
    task automatic readout(input int rmode, input int nx);
        int j;
        int cyc;
        int stall;
        bit rdy;
        j     = 0;
        cyc   = 0;
        stall = 0;
        i_read = 1'b1;
        step();
        i_read = 1'b0;
        while (j < nx && cyc < 500) begin
            chk("rd_valid", 32'(o_valid), 1);
            chk("rd_data",  32'(o_data),  32'(exp_q[j]));
            chk("rd_last",  32'(o_last),  32'(j == DEPTH - 1));
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = !(j == 5 && stall < 3);
                    if (!rdy) stall++;
                end
            endcase
            i_ready = rdy;
            step();
            if (rdy) j++;
            cyc++;
        end
        i_ready = 1'b0;
        if (j < nx) chk("readout_timeout", 32'(j), 32'(nx));
        if (nx == DEPTH) chk_zero("after_read");
    endtask

    task automatic load_ramp();
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(i);
    endtask

    task automatic ramp_run(input int p, input int lvl, input int vmode, input int rmode, input int first);
        int needed;
        load_ramp();
        needed = model_needed(p, lvl);
        capture(p, lvl, vmode, needed);
        i_arm        = 1'b1;
        i_trig_level = '0;
        i_pretrig    = '0;
        step();
        i_arm = 1'b0;
        chk("arm_in_done", 32'(o_done), 1);
        exp_q.delete();
        for (int j = 0; j < DEPTH; j++) exp_q.push_back(first + j);
        readout(rmode, DEPTH);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        i_reset      = 1'b0;
        i_signal     = '0;
        i_valid      = 1'b0;
        i_arm        = 1'b0;
        i_abort      = 1'b0;
        i_trig_level = '0;
        i_pretrig    = '0;
        i_read       = 1'b0;
        i_ready      = 1'b0;

        vecs[0] = '{p: 4,  lvl: 100, vmode: 0, rmode: 0, first: 96};
        vecs[1] = '{p: 0,  lvl: 100, vmode: 0, rmode: 0, first: 100};
        vecs[2] = '{p: 15, lvl: 100, vmode: 0, rmode: 0, first: 85};
        vecs[3] = '{p: 4,  lvl: 100, vmode: 1, rmode: 0, first: 96};
        vecs[4] = '{p: 4,  lvl: 100, vmode: 0, rmode: 2, first: 96};
        vecs[5] = '{p: 8,  lvl: 50,  vmode: 2, rmode: 1, first: 42};

        step();
        step();
        chk_zero("reset");
        i_reset = 1'b1;
        step();

        // Abort beats a simultaneous arm; read outside DONE is ignored
        i_arm        = 1'b1;
        i_abort      = 1'b1;
        i_trig_level = 8'd100;
        i_pretrig    = 4'd4;
        step();
        i_arm   = 1'b0;
        i_abort = 1'b0;
        chk("abort_over_arm", 32'(o_busy), 0);
        i_read = 1'b1;
        step();
        i_read = 1'b0;
        chk("read_in_idle", 32'(o_valid), 0);

        for (int v = 0; v < 6; v++) begin
            ramp_run(vecs[v].p, vecs[v].lvl, vecs[v].vmode, vecs[v].rmode, vecs[v].first);
        end

        // Constant input above level never triggers; abort returns to idle
        arm(4, 100);
        i_valid  = 1'b1;
        i_signal = 8'd200;
        repeat (40) step();
        chk("const_busy", 32'(o_busy), 1);
        chk("const_done", 32'(o_done), 0);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        i_valid = 1'b0;
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_valid", 32'(o_valid), 0);

        // Abort beats a simultaneous trigger
        arm(0, 100);
        i_valid  = 1'b1;
        i_signal = 8'd50;
        step();
        i_signal = 8'd150;
        i_abort  = 1'b1;
        step();
        i_abort = 1'b0;
        i_valid = 1'b0;
        chk("abort_trig_busy", 32'(o_busy), 0);
        chk("abort_trig_done", 32'(o_done), 0);

        // Reset during POST, then a fresh capture
        load_ramp();
        arm(4, 100);
        i_valid = 1'b1;
        for (int i = 0; i < 105; i++) begin
            i_signal = NB_DATA'(stim[i]);
            step();
        end
        chk("post_busy", 32'(o_busy), 1);
        i_reset = 1'b0;
        step();
        i_valid = 1'b0;
        chk_zero("reset_post");
        i_reset = 1'b1;
        ramp_run(4, 100, 0, 0, 96);

        // Reset during READ, then a fresh capture
        load_ramp();
        capture(15, 100, 0, model_needed(15, 100));
        readout(0, 3);
        i_reset = 1'b0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk_zero("reset_read");
        i_reset = 1'b1;
        ramp_run(0, 100, 0, 0, 100);

        // Randomized captures against the sample-list model
        for (int it = 0; it < 25; it++) begin
            int p;
            int lvl;
            int needed;
            needed = -1;
            p      = 0;
            lvl    = 1;
            for (int tries = 0; tries < 20 && needed < 0; tries++) begin
                p   = $urandom_range(0, 15);
                lvl = $urandom_range(1, 255);
                stim.delete();
                for (int i = 0; i < 80; i++) stim.push_back($urandom_range(0, 255));
                needed = model_needed(p, lvl);
            end
            if (needed < 0) continue;
            capture(p, lvl, 2, needed);
            readout(1, DEPTH);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
